// File: rtl/phase_acc.sv
// Phase accumulator that feeds a cordicCosSin core, serial or parallel.
// Ports: clk, reset (async, active low), sclr, en, run, freq_ld/freq,
//   phase_ofs, cordic_rdy in; st, phi, wrap, busy out.
module phase_acc #(
  parameter string CORDIC_TYPE = "SERIAL",
  parameter int    PHI_WDT     = 16,
  parameter int    ACC_WDT     = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclr,
  input  logic               en,
  input  logic               run,
  input  logic               freq_ld,
  input  logic [ACC_WDT-1:0] freq,
  input  logic [PHI_WDT-1:0] phase_ofs,
  input  logic               cordic_rdy,
  output logic               st,
  output logic [PHI_WDT-1:0] phi,
  output logic               wrap,
  output logic               busy
);

  localparam bit IS_SER = (CORDIC_TYPE == "SERIAL");

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_issue;
  logic [ACC_WDT-1:0] r_acc;
  logic [ACC_WDT-1:0] r_freq;
  logic [ACC_WDT:0]   w_sum;
  logic [PHI_WDT-1:0] w_phi;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_freq};
  assign w_phi = r_acc[ACC_WDT-1 -: PHI_WDT] + phase_ofs;
  assign busy  = (r_state != S_IDLE);

  // GUARD covers the cycle before the core's rdy has
  // had time to fall after st.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    if (IS_SER) begin
      unique case (r_state)
        S_IDLE: begin
          if (run && cordic_rdy) begin
            w_next  = S_ISSUE;
            w_issue = 1'b1;
          end
        end
        S_ISSUE: w_next = S_GUARD;
        S_GUARD: w_next = S_WAIT;
        S_WAIT: begin
          if (cordic_rdy) begin
            if (run) begin
              w_next  = S_ISSUE;
              w_issue = 1'b1;
            end else begin
              w_next = S_IDLE;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run) w_next = S_RUN;
        end
        S_RUN: begin
          if (run) w_issue = 1'b1;
          else     w_next  = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_freq  <= '0;
      st      <= 1'b0;
      wrap    <= 1'b0;
      phi     <= '0;
    end else if (sclr) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      st      <= 1'b0;
      wrap    <= 1'b0;
      phi     <= '0;
    end else if (en) begin
      r_state <= w_next;
      // issue below still sees the old r_freq
      if (freq_ld) r_freq <= freq;
      if (w_issue) begin
        st    <= 1'b1;
        phi   <= w_phi;
        wrap  <= w_sum[ACC_WDT];
        r_acc <= w_sum[ACC_WDT-1:0];
      end else begin
        st   <= 1'b0;
        wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_acc.sv
// Bench for phase_acc: SERIAL and PARALLEL instances, scoreboard checking.
// Index 0 is the serial instance, index 1 the parallel one.
module tb_phase_acc;
  localparam int PW = 16;
  localparam int AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sclr, en, freq_ld;
  logic          run_s, run_p, rdy_s, rdy_p;
  logic [AW-1:0] freq;
  logic [PW-1:0] ofs;
  logic          st_s, wrap_s, busy_s;
  logic          st_p, wrap_p, busy_p;
  logic [PW-1:0] phi_s, phi_p;

  phase_acc #(.CORDIC_TYPE("SERIAL"), .PHI_WDT(PW), .ACC_WDT(AW)) u_ser (
    .clk(clk), .reset(reset), .sclr(sclr), .en(en), .run(run_s),
    .freq_ld(freq_ld), .freq(freq), .phase_ofs(ofs),
    .cordic_rdy(rdy_s), .st(st_s), .phi(phi_s), .wrap(wrap_s),
    .busy(busy_s));

  phase_acc #(.CORDIC_TYPE("PARALLEL"), .PHI_WDT(PW), .ACC_WDT(AW)) u_par (
    .clk(clk), .reset(reset), .sclr(sclr), .en(en), .run(run_p),
    .freq_ld(freq_ld), .freq(freq), .phase_ofs(ofs),
    .cordic_rdy(rdy_p), .st(st_p), .phi(phi_p), .wrap(wrap_p),
    .busy(busy_p));

  int checks = 0;
  int errors = 0;

  logic [PW:0] q_s[$];
  logic [PW:0] q_p[$];
  logic [PW:0] e_s, e_p;
  longint      m_acc[2];
  longint      m_freq[2];
  int          seen[2];
  int          lat = 5;
  int          cnt;
  int          cyc = 0;
  int          last_iss = -1000;
  logic        en_prev = 1'b1;
  logic        rdy_prev = 1'b1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: sample i of a run reads the accumulator value before its
  // own step; wrap means that step crosses a multiple of 2^AW.
  task automatic push_exp(input int d, input longint f);
    longint      a;
    longint      m;
    logic [PW:0] e;
    m = longint'(1) << AW;
    a = m_acc[d];
    e[PW-1:0] = PW'(a >> (AW - PW)) + ofs;
    e[PW] = ((a + f) >= m);
    m_acc[d] = (a + f) % m;
    if (d == 0) q_s.push_back(e);
    else        q_p.push_back(e);
  endtask

  // Model of the serial CORDIC: rdy falls the edge after st,
  // comes back lat cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_s <= 1'b1;
      cnt   <= 0;
    end else if (en) begin
      if (st_s) begin
        rdy_s <= 1'b0;
        cnt   <= lat;
      end else if (!rdy_s) begin
        if (cnt <= 1) rdy_s <= 1'b1;
        else          cnt   <= cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    en_prev  = en;
    rdy_prev = rdy_s;
    cyc      = cyc + 1;
  end

  // Monitor: a fresh sample is st high after an enabled edge.
  always @(negedge clk) begin
    if (reset && en_prev) begin
      if (st_s) begin
        seen[0]++;
        chk("ser_sample_expected", q_s.size() > 0, 1);
        if (q_s.size() > 0) begin
          e_s = q_s.pop_front();
          chk("ser_phi", phi_s, e_s[PW-1:0]);
          chk("ser_wrap", wrap_s, e_s[PW]);
        end
        chk("ser_st_with_rdy", rdy_prev, 1);
        chk("ser_spacing", (cyc - last_iss) >= lat + 2, 1);
        last_iss = cyc;
      end
      if (st_p) begin
        seen[1]++;
        chk("par_sample_expected", q_p.size() > 0, 1);
        if (q_p.size() > 0) begin
          e_p = q_p.pop_front();
          chk("par_phi", phi_p, e_p[PW-1:0]);
          chk("par_wrap", wrap_p, e_p[PW]);
        end
      end
    end
  end

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy_s : busy_p;
  endfunction

  task automatic wait_seen(input int d, input int n, input bit ren);
    int b = 0;
    while (seen[d] < n && b < 3000) begin
      @(negedge clk);
      #1;
      b++;
      rdy_p = 1'($urandom_range(0, 1));
      if (ren && seen[d] < n) en = ($urandom_range(0, 3) != 0);
    end
    chk("wait_samples", seen[d], n);
  endtask

  task automatic wait_idle(input int d, input bit ren);
    int b = 0;
    while (busy_of(d) && b < 3000) begin
      @(negedge clk);
      #1;
      b++;
      rdy_p = 1'($urandom_range(0, 1));
      if (ren) en = ($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
    chk("wait_idle", busy_of(d), 0);
  endtask

  task automatic run_seg(input int d, input int k, input bit ren);
    int tgt;
    for (int i = 0; i < k; i++) push_exp(d, m_freq[d]);
    last_iss = -1000;
    tgt = seen[d] + k;
    if (d == 0) run_s = 1'b1;
    else        run_p = 1'b1;
    wait_seen(d, tgt, ren);
    run_s = 1'b0;
    run_p = 1'b0;
    wait_idle(d, ren);
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    chk("queue_drained", (d == 0) ? q_s.size() : q_p.size(), 0);
  endtask

  task automatic load_freq(input logic [AW-1:0] f);
    freq    = f;
    freq_ld = 1'b1;
    @(negedge clk);
    #1;
    freq_ld   = 1'b0;
    m_freq[0] = f;
    m_freq[1] = f;
  endtask

  task automatic do_sclr();
    sclr = 1'b1;
    @(negedge clk);
    #1;
    sclr     = 1'b0;
    m_acc[0] = 0;
    m_acc[1] = 0;
  endtask

  initial begin
    int base;
    reset = 1'b0; sclr = 1'b0; en = 1'b1; freq_ld = 1'b0;
    run_s = 1'b0; run_p = 1'b0; rdy_p = 1'b0;
    freq = '0; ofs = '0;
    m_acc[0] = 0; m_acc[1] = 0; m_freq[0] = 0; m_freq[1] = 0;
    seen[0] = 0; seen[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ser_st", st_s, 0);
    chk("rst_ser_phi", phi_s, 0);
    chk("rst_ser_wrap", wrap_s, 0);
    chk("rst_ser_busy", busy_s, 0);
    chk("rst_par_st", st_p, 0);
    chk("rst_par_phi", phi_p, 0);
    chk("rst_par_wrap", wrap_p, 0);
    chk("rst_par_busy", busy_p, 0);
    #1 reset = 1'b1;

    // Parallel, small step: phi 0..4, no wrap.
    load_freq(24'h000100);
    run_seg(1, 5, 0);

    // Parallel, half-turn step: wraps on every other sample.
    do_sclr();
    load_freq(24'h800000);
    run_seg(1, 4, 0);

    // Serial with offset and CORDIC latency.
    do_sclr();
    load_freq(24'h000100);
    ofs = 16'h4000;
    lat = 5;
    run_seg(0, 5, 0);

    // Serial, run dropped while waiting on the core.
    push_exp(0, m_freq[0]);
    last_iss = -1000;
    base = seen[0];
    run_s = 1'b1;
    wait_seen(0, base + 1, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    run_s = 1'b0;
    begin
      int b = 0;
      while (!rdy_s && b < 100) begin
        @(negedge clk);
        #1;
        b++;
      end
    end
    chk("drop_rdy_back", rdy_s, 1);
    chk("drop_busy_at_rdy", busy_s, 1);
    @(negedge clk);
    #1;
    chk("drop_busy_after_rdy", busy_s, 0);
    repeat (6) begin
      @(negedge clk);
      #1;
    end
    chk("drop_no_extra", seen[0], base + 1);

    // Parallel, freq load on an issue edge: steps +1, +1, +2.
    ofs = 16'h0000;
    push_exp(1, 24'h000100);
    push_exp(1, 24'h000100);
    push_exp(1, 24'h000200);
    push_exp(1, 24'h000200);
    base = seen[1];
    run_p = 1'b1;
    wait_seen(1, base + 1, 0);
    freq    = 24'h000200;
    freq_ld = 1'b1;
    @(negedge clk);
    #1;
    freq_ld   = 1'b0;
    m_freq[0] = 24'h000200;
    m_freq[1] = 24'h000200;
    wait_seen(1, base + 4, 0);
    run_p = 1'b0;
    wait_idle(1, 0);
    chk("fld_drained", q_p.size(), 0);

    // Parallel, sclr mid-run, then restart with the same step.
    push_exp(1, m_freq[1]);
    push_exp(1, m_freq[1]);
    base = seen[1];
    run_p = 1'b1;
    wait_seen(1, base + 2, 0);
    sclr  = 1'b1;
    run_p = 1'b0;
    @(negedge clk);
    chk("sclr_st", st_p, 0);
    chk("sclr_phi", phi_p, 0);
    chk("sclr_wrap", wrap_p, 0);
    chk("sclr_busy", busy_p, 0);
    #1 sclr = 1'b0;
    m_acc[0] = 0;
    m_acc[1] = 0;
    ofs = 16'h0777;
    run_seg(1, 3, 0);

    // Serial, reset while waiting on the core, then restart.
    push_exp(0, m_freq[0]);
    last_iss = -1000;
    base = seen[0];
    run_s = 1'b1;
    wait_seen(0, base + 1, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    run_s = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_st", st_s, 0);
    chk("arst_phi", phi_s, 0);
    chk("arst_wrap", wrap_s, 0);
    chk("arst_busy", busy_s, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    m_acc[0] = 0; m_acc[1] = 0; m_freq[0] = 0; m_freq[1] = 0;
    chk("arst_q", q_s.size(), 0);
    load_freq(24'h000100);
    ofs = 16'h1234;
    run_seg(0, 2, 0);

    // Randomized segments with enable gaps.
    for (int it = 0; it < 24; it++) begin
      int d;
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) load_freq(AW'($urandom));
      if ($urandom_range(0, 5) == 0) do_sclr();
      ofs = PW'($urandom);
      lat = $urandom_range(1, 6);
      run_seg(d, $urandom_range(1, 6), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_acc.md
PHASE_ACC -- requirements
Module: phase_acc

Interface
REQ-001 SHALL have parameter CORDIC_TYPE, default "SERIAL", meaning the attached cordicCosSin variant ("SERIAL" or "PARALLEL").
REQ-002 SHALL have parameter PHI_WDT, default 16, meaning the phase output width, equal to the CORDIC PHI_WDT.
REQ-003 SHALL have parameter ACC_WDT, default 24, meaning the accumulator and tuning word width; ACC_WDT >= PHI_WDT.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all registers are rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sclr, input, 1 bit: synchronous clear.
REQ-007 SHALL have port en, input, 1 bit: clock enable; all registers hold while en=0.
REQ-008 SHALL have port run, input, 1 bit: level request to generate samples.
REQ-009 SHALL have port freq_ld, input, 1 bit: load strobe for freq.
REQ-010 SHALL have port freq, input, ACC_WDT bits, unsigned: the tuning word.
REQ-011 SHALL have port phase_ofs, input, PHI_WDT bits: the phase offset, sampled every issue.
REQ-012 SHALL have port cordic_rdy, input, 1 bit: the rdy output of cordicCosSin.
REQ-013 SHALL have port st, output, 1 bit: start strobe to the CORDIC.
REQ-014 SHALL have port phi, output, PHI_WDT bits: phase to the CORDIC, valid when st=1.
REQ-015 SHALL have port wrap, output, 1 bit: accumulator carry-out, coincident with st.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL keep registers freq_r (ACC_WDT) and acc (ACC_WDT); accumulation is modulo 2^ACC_WDT and silently wraps.
REQ-018 SHALL, on any enabled edge with freq_ld=1, load freq_r<=freq; an issue on the same edge uses the old freq_r.
REQ-019 SHALL, on each issue edge: st<=1; phi<=acc[ACC_WDT-1 -: PHI_WDT]+phase_ofs, modulo 2^PHI_WDT, truncated with no rounding; wrap<=carry-out of acc+freq_r; acc<=acc+freq_r.
REQ-020 SHALL drive st and wrap low on every enabled edge that is not an issue edge; phi holds its last value.
REQ-021 SHALL, for PARALLEL, implement states IDLE and RUN: IDLE->RUN when run=1; RUN->IDLE when run=0; every enabled edge in RUN with run=1 is an issue edge (one sample per cycle; cordic_rdy ignored).
REQ-022 SHALL, for SERIAL, implement states IDLE, ISSUE, GUARD and WAIT:
- IDLE->ISSUE when run=1 and cordic_rdy=1; the edge entering ISSUE is the issue edge.
- ISSUE->GUARD unconditionally.
- GUARD->WAIT unconditionally; cordic_rdy is ignored in GUARD.
- WAIT->ISSUE (issue edge) when cordic_rdy=1 and run=1.
- WAIT->IDLE when cordic_rdy=1 and run=0.
- Otherwise WAIT holds.
REQ-023 SHALL, in SERIAL, never assert st on two edges less than 3 cycles apart, and never while cordic_rdy=0.
REQ-024 SHALL, when run is deasserted mid-sample in SERIAL, complete the outstanding sample (ISSUE/GUARD/WAIT) and then enter IDLE, with no new st.
REQ-025 SHALL give reset priority over sclr, and sclr priority over en=0.
REQ-026 SHALL make sclr=1 clear acc, st, wrap and phi, and force IDLE; freq_r is retained.
REQ-027 SHALL make en=0 freeze the state, acc, freq_r and all outputs, including st if it is high.

Reset
REQ-028 SHALL, on reset=0 (asynchronous), set acc=0, freq_r=0, phi=0, st=0, wrap=0, busy=0 and state=IDLE.
REQ-029 SHALL leave reset mid-sample to abandon the sample; after release, the next issue starts from acc=0.

Verification
REQ-030 PARALLEL, freq=0x000100, phase_ofs=0, run=1 for 5 cycles -> st=1 for 5 consecutive cycles with phi=0,1,2,3,4; wrap=0.
REQ-031 PARALLEL, freq=0x800000, run=1 -> phi=0x0000,0x8000,0x0000,...; wrap=1 on the 2nd, 4th, ... st.
REQ-032 SERIAL with a cordicCosSin model (rdy drops the cycle after st, returns N cycles later), freq=0x000100, phase_ofs=0x4000 -> successive st carry phi=0x4000,0x4001,...; spacing is N+2 or more cycles; no st while rdy=0.
REQ-033 SERIAL, run dropped during WAIT -> no further st; busy falls the edge after rdy rises.
REQ-034 freq_ld on an issue edge, changing freq 0x000100->0x000200 -> the next two phi steps are +1, then +2.
REQ-035 sclr during RUN -> next cycle st=0, phi=0, state IDLE; the next run restarts at phi=phase_ofs with the same freq step; reset mid-WAIT gives the same restart behaviour.
